acc_cpu_control: RTL and testbench

Multi-cycle control unit for the 16-bit accumulator processor. Each cycle it drives the load enables and selects for the PC/IR/ACC/MDR/MAR register bank, the RAM write strobe and the iterative divider's Load/Done handshake, sequencing fetch, decode and execute for one instruction at a time. It sits between `registers`, `ram` and `my8bitdivider` inside `proj1`, and is the only block that changes machine state.

---
 rtl/acc_cpu_control.sv | 140 ++++++++++++++
 tb/tb_acc_cpu_control.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_cpu_control.sv
// Multi-cycle control FSM for the 16-bit accumulator CPU: fetch, decode, execute,
// and an iterative-divider handshake with a timeout. halted and err are sticky.
module acc_cpu_control #(
  parameter int DIV_TIMEOUT = 200000
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [15:0] ir,
  input  logic        zflag,
  input  logic        mdr_zero,
  input  logic        div_done,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        ir_ld,
  output logic        mar_sel,
  output logic        mar_ld,
  output logic        mdr_ld,
  output logic        mem_we,
  output logic        acc_ld,
  output logic [1:0]  alu_op,
  output logic        div_load,
  output logic        halted,
  output logic [1:0]  err
);
  localparam logic [3:0] S_F0    = 4'd0;
  localparam logic [3:0] S_F1    = 4'd1;
  localparam logic [3:0] S_F2    = 4'd2;
  localparam logic [3:0] S_DEC   = 4'd3;
  localparam logic [3:0] S_OA    = 4'd4;
  localparam logic [3:0] S_OR    = 4'd5;
  localparam logic [3:0] S_OW    = 4'd6;
  localparam logic [3:0] S_SA    = 4'd7;
  localparam logic [3:0] S_SW    = 4'd8;
  localparam logic [3:0] S_DCHK  = 4'd9;
  localparam logic [3:0] S_DST   = 4'd10;
  localparam logic [3:0] S_DWAIT = 4'd11;
  localparam logic [3:0] S_DWB   = 4'd12;
  localparam logic [3:0] S_HALT  = 4'd13;

  localparam logic [3:0] OP_NOP = 4'd0, OP_LOAD = 4'd1, OP_STORE = 4'd2, OP_ADD = 4'd3,
                         OP_SUB = 4'd4, OP_DIV  = 4'd5, OP_JMP   = 4'd6, OP_JZ  = 4'd7,
                         OP_HALT = 4'd8;

  localparam logic [1:0] ERR_NONE = 2'd0, ERR_DIV0 = 2'd1, ERR_TMO = 2'd2, ERR_ILL = 2'd3;
  localparam logic [17:0] TMO_LAST = 18'(DIV_TIMEOUT - 1);

  logic [3:0]  state, nxt;
  logic [17:0] cnt;
  logic [3:0]  op;
  logic        err_set;
  logic [1:0]  err_code;
  logic        unused_ir;

  assign op        = ir[15:12];
  assign unused_ir = ^ir[11:0];

  always_comb begin
    nxt      = state;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    ir_ld    = 1'b0;
    mar_sel  = 1'b0;
    mar_ld   = 1'b0;
    mdr_ld   = 1'b0;
    mem_we   = 1'b0;
    acc_ld   = 1'b0;
    alu_op   = 2'd0;
    div_load = 1'b0;
    err_set  = 1'b0;
    err_code = ERR_NONE;
    case (state)
      S_F0:  begin mar_ld = 1'b1; nxt = S_F1; end
      S_F1:  begin mdr_ld = 1'b1; nxt = S_F2; end
      S_F2:  begin ir_ld = 1'b1; pc_inc = 1'b1; nxt = S_DEC; end
      S_DEC: begin
        case (op)
          OP_NOP:  nxt = S_F0;
          OP_JMP:  begin pc_load = 1'b1; nxt = S_F0; end
          OP_JZ:   begin pc_load = zflag; nxt = S_F0; end
          OP_HALT: nxt = S_HALT;
          OP_LOAD, OP_ADD, OP_SUB, OP_DIV: nxt = S_OA;
          OP_STORE: nxt = S_SA;
          default: begin err_set = 1'b1; err_code = ERR_ILL; nxt = S_HALT; end
        endcase
      end
      S_OA:  begin mar_sel = 1'b1; mar_ld = 1'b1; nxt = S_OR; end
      S_OR:  begin mdr_ld = 1'b1; nxt = (op == OP_DIV) ? S_DCHK : S_OW; end
      S_OW:  begin
        acc_ld = 1'b1;
        alu_op = (op == OP_ADD) ? 2'd1 : (op == OP_SUB) ? 2'd2 : 2'd0;
        nxt    = S_F0;
      end
      S_SA:  begin mar_sel = 1'b1; mar_ld = 1'b1; nxt = S_SW; end
      S_SW:  begin mem_we = 1'b1; nxt = S_F0; end
      // Zero divisor is caught before the divider is ever started.
      S_DCHK: begin
        if (mdr_zero) begin err_set = 1'b1; err_code = ERR_DIV0; nxt = S_HALT; end
        else nxt = S_DST;
      end
      S_DST: begin div_load = 1'b1; nxt = S_DWAIT; end
      S_DWAIT: begin
        if (div_done) nxt = S_DWB;
        else if (cnt == TMO_LAST) begin err_set = 1'b1; err_code = ERR_TMO; nxt = S_HALT; end
      end
      S_DWB:  begin acc_ld = 1'b1; alu_op = 2'd3; nxt = S_F0; end
      S_HALT: nxt = S_HALT;
      default: nxt = S_F0;
    endcase
    // Nothing may touch machine state while Reset is held.
    if (Reset) begin
      pc_inc   = 1'b0;
      pc_load  = 1'b0;
      ir_ld    = 1'b0;
      mar_sel  = 1'b0;
      mar_ld   = 1'b0;
      mdr_ld   = 1'b0;
      mem_we   = 1'b0;
      acc_ld   = 1'b0;
      alu_op   = 2'd0;
      div_load = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state  <= S_F0;
      halted <= 1'b0;
      err    <= ERR_NONE;
      cnt    <= '0;
    end else begin
      state <= nxt;
      if (nxt == S_HALT) halted <= 1'b1;
      if (err_set && err == ERR_NONE) err <= err_code;
      if (state == S_DST) cnt <= '0;
      else if (state == S_DWAIT) cnt <= cnt + 18'd1;
    end
  end

  a_pc_excl: assert property (@(posedge clk) disable iff (Reset) !(pc_load && pc_inc));
endmodule

// File: tb/tb_acc_cpu_control.sv
// Bench for acc_cpu_control: emulated datapath/RAM/divider around the FSM, hand vectors
// for the listed corner cases, and random straight-line programs against an ISA-level model.
module tb_acc_cpu_control;
  localparam int TMO = 16;

  logic clk = 1'b0, Reset = 1'b1;
  logic [15:0] ir;
  logic zflag, mdr_zero, div_done;
  logic pc_inc, pc_load, ir_ld, mar_sel, mar_ld, mdr_ld, mem_we, acc_ld, div_load, halted;
  logic [1:0] alu_op, err;
  logic [14:0] outs;

  acc_cpu_control #(.DIV_TIMEOUT(TMO)) dut (
    .clk(clk), .Reset(Reset), .ir(ir), .zflag(zflag), .mdr_zero(mdr_zero),
    .div_done(div_done), .pc_inc(pc_inc), .pc_load(pc_load), .ir_ld(ir_ld),
    .mar_sel(mar_sel), .mar_ld(mar_ld), .mdr_ld(mdr_ld), .mem_we(mem_we),
    .acc_ld(acc_ld), .alu_op(alu_op), .div_load(div_load), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;
  assign outs = {pc_inc, pc_load, ir_ld, mar_sel, mar_ld, mdr_ld, mem_we, acc_ld,
                 alu_op, div_load, halted, err};

  // ---------------- emulated datapath, RAM and divider ----------------
  logic [15:0] mem [256];
  logic [15:0] init_mem [256];
  logic [7:0]  pc, mar;
  logic [15:0] acc, mdr, dv_q;
  logic        dv_busy, dv_done;
  int          dv_cnt, div_lat;
  bit          div_never;

  assign zflag    = (acc == 16'd0);
  assign mdr_zero = (mdr == 16'd0);
  assign div_done = dv_done;

  always @(posedge clk) begin
    if (Reset) begin
      pc <= 8'd0; mar <= 8'd0; ir <= 16'd0; acc <= 16'd0; mdr <= 16'd0;
      mem <= init_mem; dv_busy <= 1'b0; dv_done <= 1'b0; dv_cnt <= 0; dv_q <= 16'd0;
    end else begin
      if (pc_inc)  pc <= pc + 8'd1;
      if (pc_load) pc <= ir[7:0];
      if (ir_ld)   ir <= mdr;
      if (mar_ld)  mar <= mar_sel ? ir[7:0] : pc;
      if (mdr_ld)  mdr <= mem[mar];
      if (mem_we)  mem[mar] <= acc;
      if (acc_ld)
        case (alu_op)
          2'd0: acc <= mdr;
          2'd1: acc <= acc + mdr;
          2'd2: acc <= acc - mdr;
          default: acc <= dv_q;
        endcase
      if (div_load) begin
        dv_busy <= !div_never; dv_cnt <= div_lat; dv_done <= 1'b0;
        dv_q <= (mdr == 16'd0) ? 16'hFFFF : acc / mdr;
      end else if (dv_busy) begin
        if (dv_cnt <= 1) begin dv_done <= 1'b1; dv_busy <= 1'b0; end
        else dv_cnt <= dv_cnt - 1;
      end
    end
  end

  // ---------------- monitor (cycle 0 = first F0 after Reset) ----------------
  int cyc, halt_cyc, n_divld;
  int f0_q[$];

  always @(negedge clk) begin
    if (Reset) begin
      cyc <= 0; halt_cyc <= -1; n_divld <= 0; f0_q.delete();
    end else begin
      cyc <= cyc + 1;
      if (mar_ld && !mar_sel) f0_q.push_back(cyc);
      if (halted && halt_cyc < 0) halt_cyc <= cyc;
      if (div_load) n_divld <= n_divld + 1;
    end
  end

  // ---------------- checking helpers ----------------
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 Reset = 1'b1;
    @(posedge clk);
    @(negedge clk); chk("reset_outputs", outs, 15'd0);
    @(posedge clk); #1 Reset = 1'b0;
  endtask

  task automatic run_prog();
    int c;
    do_reset();
    c = 0;
    while (!halted && c < 3000) begin @(negedge clk); #1; c++; end
    chk("halt_reached", halted, 1'b1);
    repeat (2) @(negedge clk);
    #1;
  endtask

  // ---------------- ISA-level reference model ----------------
  logic [15:0] r_mem [256];
  logic [15:0] r_acc;
  logic [7:0]  r_pc;
  int r_err, r_halt, r_divs;
  int r_f0[$];

  task automatic ref_run();
    int t;
    logic [15:0] ins;
    logic [7:0] a;
    bit stop;
    r_mem = init_mem; r_acc = 0; r_pc = 0; r_err = 0; r_divs = 0; r_f0.delete();
    t = 0; stop = 0;
    for (int k = 0; k < 300 && !stop; k++) begin
      r_f0.push_back(t);
      ins = r_mem[r_pc]; a = ins[7:0]; r_pc = r_pc + 8'd1;
      case (ins[15:12])
        4'd0: t += 4;
        4'd1: begin r_acc = r_mem[a]; t += 7; end
        4'd2: begin r_mem[a] = r_acc; t += 6; end
        4'd3: begin r_acc = r_acc + r_mem[a]; t += 7; end
        4'd4: begin r_acc = r_acc - r_mem[a]; t += 7; end
        4'd5: begin
          if (r_mem[a] == 0) begin r_err = 1; t += 7; stop = 1; end
          else if (div_never) begin r_divs++; r_err = 2; t += 8 + TMO; stop = 1; end
          else begin r_divs++; r_acc = r_acc / r_mem[a]; t += 9 + (div_lat + 1); end
        end
        4'd6: begin r_pc = a; t += 4; end
        4'd7: begin if (r_acc == 0) r_pc = a; t += 4; end
        4'd8: begin t += 4; stop = 1; end
        default: begin r_err = 3; t += 4; stop = 1; end
      endcase
    end
    r_halt = t;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int n;
    logic [5:0][23:0] p;   // {addr, data} memory preload pairs; other words hold HALT
    int lat; bit nev;
    int eacc, eerr, epc, ehalt, ca, cd, edivs;
  } vec_t;

  function automatic vec_t mk(int n, logic [23:0] p0, logic [23:0] p1, logic [23:0] p2,
                              logic [23:0] p3, logic [23:0] p4, logic [23:0] p5,
                              int lat, bit nev, int eacc, int eerr, int epc, int ehalt,
                              int ca, int cd, int edivs);
    vec_t v;
    v.n = n; v.p[0] = p0; v.p[1] = p1; v.p[2] = p2; v.p[3] = p3; v.p[4] = p4; v.p[5] = p5;
    v.lat = lat; v.nev = nev; v.eacc = eacc; v.eerr = eerr; v.epc = epc; v.ehalt = ehalt;
    v.ca = ca; v.cd = cd; v.edivs = edivs;
    return v;
  endfunction

  task automatic load_vec(input vec_t v);
    for (int k = 0; k < 256; k++) init_mem[k] = 16'h8000;
    for (int j = 0; j < v.n; j++) init_mem[v.p[j][23:16]] = v.p[j][15:0];
    div_lat = v.lat; div_never = v.nev;
  endtask

  vec_t tbl [10];

  initial begin
    int nbad, n, r;
    logic [3:0] op;
    logic [7:0] ad;

    tbl[0] = mk(6, 24'h00_1010, 24'h01_3011, 24'h02_2012, 24'h03_8000, 24'h10_0005, 24'h11_0007,
                1, 0, 12, 0, 4, 24, 'h12, 12, 0);
    tbl[1] = mk(3, 24'h00_1010, 24'h01_7020, 24'h10_0000, 0, 0, 0,
                1, 0, 0, 0, 'h21, 15, 'h10, 0, 0);
    tbl[2] = mk(4, 24'h00_1010, 24'h01_7020, 24'h10_0003, 24'h20_F000, 0, 0,
                1, 0, 3, 0, 3, 15, 'h10, 3, 0);
    tbl[3] = mk(4, 24'h00_1010, 24'h01_5011, 24'h10_0064, 24'h11_0007, 0, 0,
                3, 0, 14, 0, 3, 24, 'h11, 7, 1);
    tbl[4] = mk(6, 24'h00_1010, 24'h01_5011, 24'h02_5012, 24'h10_0064, 24'h11_0007, 24'h12_0002,
                2, 0, 7, 0, 4, 35, 'h12, 2, 2);
    tbl[5] = mk(4, 24'h00_1010, 24'h01_5011, 24'h10_0064, 24'h11_0000, 0, 0,
                1, 0, 100, 1, 2, 14, 'h11, 0, 0);
    tbl[6] = mk(1, 24'h00_B000, 0, 0, 0, 0, 0,
                1, 0, 0, 3, 1, 4, 'h00, 'hB000, 0);
    tbl[7] = mk(3, 24'h00_0000, 24'h01_6005, 24'h02_F000, 0, 0, 0,
                1, 0, 0, 0, 6, 12, 'h02, 'hF000, 0);
    tbl[8] = mk(4, 24'h00_1010, 24'h01_60FF, 24'hFF_2000, 24'h10_8000, 0, 0,
                1, 0, 'h8000, 0, 1, 21, 'h00, 'h8000, 0);
    tbl[9] = mk(4, 24'h00_1010, 24'h01_5011, 24'h10_0064, 24'h11_0007, 0, 0,
                0, 1, 100, 2, 2, 31, 'h11, 7, 1);

    for (int i = 0; i < 10; i++) begin
      load_vec(tbl[i]);
      run_prog();
      chk($sformatf("v%0d_halt_cycle", i), halt_cyc, tbl[i].ehalt);
      chk($sformatf("v%0d_err", i), err, tbl[i].eerr);
      chk($sformatf("v%0d_acc", i), acc, tbl[i].eacc);
      chk($sformatf("v%0d_pc", i), pc, tbl[i].epc);
      chk($sformatf("v%0d_mem", i), mem[tbl[i].ca], tbl[i].cd);
      chk($sformatf("v%0d_div_loads", i), n_divld, tbl[i].edivs);
    end

    // After the timeout vector: Reset clears halted/err and restarts in F0,
    // then Reset again from inside DWAIT abandons the divide.
    do_reset();
    @(negedge clk);
    chk("f0_after_timeout_reset", {mar_ld, mar_sel, halted, err}, 5'b10000);
    repeat (18) @(posedge clk);
    #1 chk("dwait_quiet", outs, 15'd0);
    Reset = 1'b1;
    @(posedge clk);
    @(negedge clk) chk("dwait_rst_div_load", {div_load, acc_ld}, 2'b00);
    @(posedge clk); #1 Reset = 1'b0;
    @(negedge clk) chk("f0_after_dwait_rst", {mar_ld, mar_sel, halted, err}, 5'b10000);

    // Reset during OR of an ADD: no accumulator load, no write, F0 next.
    for (int k = 0; k < 256; k++) init_mem[k] = 16'h8000;
    init_mem[0] = 16'h3011; init_mem[8'h11] = 16'h0007; div_never = 0; div_lat = 1;
    do_reset();
    @(negedge clk);
    repeat (5) @(posedge clk);
    #1 chk("in_or", {mdr_ld, mar_ld, acc_ld}, 3'b100);
    Reset = 1'b1;
    @(negedge clk) chk("or_rst_outputs", outs, 15'd0);
    @(posedge clk);
    @(negedge clk) chk("or_rst_no_write", {acc_ld, mem_we}, 2'b00);
    @(posedge clk); #1 Reset = 1'b0;
    @(negedge clk) chk("f0_after_or_rst", {mar_ld, mar_sel, acc}, {2'b10, 16'd0});

    // Random forward-branching programs vs the ISA model.
    for (int t = 0; t < 12; t++) begin
      for (int k = 0; k < 256; k++) init_mem[k] = 16'h8000;
      n = $urandom_range(4, 12);
      for (int i = 0; i < n - 1; i++) begin
        r = $urandom_range(0, 19);
        ad = 8'h80 + 8'($urandom_range(0, 7));
        if (r == 0) op = 4'd0;
        else if (r <= 4) op = 4'd1;
        else if (r <= 6) op = 4'd2;
        else if (r <= 9) op = 4'd3;
        else if (r <= 11) op = 4'd4;
        else if (r <= 14) op = 4'd5;
        else if (r == 15) op = 4'd6;
        else if (r <= 18) op = 4'd7;
        else op = 4'($urandom_range(9, 15));
        if (op == 4'd6 || op == 4'd7) ad = 8'($urandom_range(i + 1, n - 1));
        init_mem[i] = {op, 4'h0, ad};
      end
      for (int k = 0; k < 8; k++)
        init_mem[8'h80 + k] = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 60));
      div_lat = $urandom_range(1, 6); div_never = 0;
      ref_run();
      run_prog();
      chk($sformatf("r%0d_f0_count", t), f0_q.size(), r_f0.size());
      nbad = 0;
      for (int k = 0; k < f0_q.size() && k < r_f0.size(); k++) if (f0_q[k] != r_f0[k]) nbad++;
      chk($sformatf("r%0d_f0_times_bad", t), nbad, 0);
      chk($sformatf("r%0d_halt_cycle", t), halt_cyc, r_halt);
      chk($sformatf("r%0d_err", t), err, r_err);
      chk($sformatf("r%0d_acc", t), acc, r_acc);
      chk($sformatf("r%0d_pc", t), pc, r_pc);
      chk($sformatf("r%0d_div_loads", t), n_divld, r_divs);
      nbad = 0;
      for (int k = 0; k < 256; k++) if (mem[k] !== r_mem[k]) nbad++;
      chk($sformatf("r%0d_mem_bad_words", t), nbad, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
